// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(63,51) encoder/checker pair.
package bch_pkg;
  localparam int N = 63;
  localparam int K = 51;
  localparam int M = 12;
  localparam logic [M-1:0] GEN_POLY = 12'h539;

  localparam int IN_CNT_W  = $clog2(N);
  localparam int OUT_CNT_W = $clog2(K);

  typedef enum logic {RX_DATA, RX_PARITY} rx_state_t;
endpackage

// File: rtl/bch_parity_lfsr.sv
// Serial parity LFSR for g(x); feedback during message bits, plain shift-out during parity bits.
module bch_parity_lfsr
  import bch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_clear,
  input  logic         i_shift_en,
  input  logic         i_feedback_en,
  input  logic         i_din,
  output logic [M-1:0] o_par
);

  logic [M-1:0] r_par;
  logic         w_fb;

  assign w_fb  = i_feedback_en & (i_din ^ r_par[M-1]);
  assign o_par = r_par;

  always_ff @(posedge i_clk) begin
    if (i_clear)
      r_par <= '0;
    else if (i_shift_en)
      r_par <= {r_par[M-2:0], 1'b0} ^ (w_fb ? GEN_POLY : '0);
  end

endmodule

// File: rtl/bch_checker.sv
// BCH(63,51) receive-side checker: serial codeword in, message bits out with per-block
// syndrome/error flag, ping-pong buffered so one block fills while the other drains.
module bch_checker
  import bch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic             data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             data_out,
  output logic             last_out,
  output logic             err_out,
  output logic [M-1:0]     syndrome_out,
  output logic [CNT_W-1:0] blk_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(N - 1);
  localparam logic [IN_CNT_W-1:0]  MSG_LAST = IN_CNT_W'(K - 1);
  localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(K - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rx_state_t             r_state, w_state_nxt;
  logic [IN_CNT_W-1:0]   r_in_cnt, w_in_cnt_nxt;
  logic [OUT_CNT_W-1:0]  r_out_cnt;
  logic                  r_wr_bank, r_rd_bank;
  logic [1:0]            r_full;
  logic [K-1:0]          r_data     [2];
  logic [M-1:0]          r_bank_syn [2];
  logic [1:0]            r_err;
  logic [M-1:0]          r_syn;
  logic [CNT_W-1:0]      r_blk_count, r_err_count;

  logic                  w_in_fire, w_in_last, w_out_fire, w_out_last;
  logic [M-1:0]          w_par;
  logic                  w_par_bit;
  logic [IN_CNT_W-1:0]   w_syn_pos;
  logic [M-1:0]          w_syn_final;

  assign ready_in   = !r_full[r_wr_bank];
  assign w_in_fire  = valid_in && ready_in;
  assign w_in_last  = w_in_fire && (r_in_cnt == IN_LAST);
  assign w_out_fire = valid_out && ready_out;
  assign w_out_last = w_out_fire && (r_out_cnt == OUT_LAST);

  // First parity bit lands in syn[M-1]; the final bit (in_cnt=N-1) is syn[0].
  assign w_par_bit   = data_in ^ w_par[M-1];
  assign w_syn_pos   = IN_LAST - r_in_cnt;
  assign w_syn_final = {r_syn[M-1:1], w_par_bit};

  bch_parity_lfsr u_lfsr (
    .i_clk         (clk),
    .i_clear       (rst || w_in_last),
    .i_shift_en    (w_in_fire),
    .i_feedback_en (r_state == RX_DATA),
    .i_din         (data_in),
    .o_par         (w_par)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_in_cnt_nxt = r_in_cnt;
    if (w_in_fire) begin
      if (r_in_cnt == IN_LAST) begin
        w_in_cnt_nxt = '0;
        w_state_nxt  = RX_DATA;
      end else begin
        w_in_cnt_nxt = r_in_cnt + 1'b1;
        if (r_in_cnt == MSG_LAST)
          w_state_nxt = RX_PARITY;
      end
    end
  end

  // Bank payload: written only on accepted bits, qualified by full on the read side.
  always_ff @(posedge clk) begin
    if (w_in_fire && r_state == RX_DATA)
      r_data[r_wr_bank][r_in_cnt] <= data_in;
    if (w_in_fire && r_state == RX_PARITY)
      r_syn[w_syn_pos[3:0]] <= w_par_bit;
    if (w_in_last) begin
      r_bank_syn[r_wr_bank] <= w_syn_final;
      r_err[r_wr_bank]      <= |w_syn_final;
    end
  end

  // Control: FSM, bank pointers, full flags, output counter, statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RX_DATA;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_full      <= '0;
      r_blk_count <= '0;
      r_err_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_cnt <= w_in_cnt_nxt;
      if (w_in_last) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
        r_blk_count       <= sat_inc(r_blk_count);
        if (|w_syn_final)
          r_err_count <= sat_inc(r_err_count);
      end
      // A fill and a drain in the same cycle always target different banks.
      if (w_out_last) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
        r_out_cnt         <= '0;
      end else if (w_out_fire) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

  assign valid_out    = r_full[r_rd_bank];
  assign data_out     = r_data[r_rd_bank][r_out_cnt];
  assign last_out     = valid_out && (r_out_cnt == OUT_LAST);
  assign err_out      = valid_out && r_err[r_rd_bank];
  assign syndrome_out = valid_out ? r_bank_syn[r_rd_bank] : '0;
  assign blk_count    = r_blk_count;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_bch_checker.sv
// Bench for bch_checker: directed and random codewords scored against a polynomial-division model.
module tb_bch_checker;

  localparam int TN = 63;
  localparam int TK = 51;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_in, data_in;
  logic        valid_out, ready_out, data_out, last_out, err_out;
  logic [11:0] syndrome_out;
  logic [15:0] blk_count, err_count;

  int checks   = 0;
  int failures = 0;

  bit          tx_q[$];
  bit          exp_bit_q[$];
  logic [11:0] exp_syn_q[$];
  int          out_pos = 0;
  int          acc     = 0;
  int          vi_pct  = 100;
  int          ro_pct  = 100;
  bit          s_vo;
  bit          ri_low_seen;
  logic [11:0] last_syn;
  logic        last_err;
  int          nerr;

  always #5 clk = ~clk;

  bch_checker #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .data_in      (data_in),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .last_out     (last_out),
    .err_out      (err_out),
    .syndrome_out (syndrome_out),
    .blk_count    (blk_count),
    .err_count    (err_count)
  );

  // Codeword vector: transmitted bit i sits at degree 62-i.
  function automatic logic [11:0] poly_mod(input logic [62:0] r);
    logic [62:0] c;
    c = r;
    for (int d = 62; d >= 12; d--)
      if (c[d]) c = c ^ (63'h1539 << (d - 12));
    return c[11:0];
  endfunction

  function automatic logic [62:0] encode(input logic [50:0] msg);
    logic [62:0] r;
    r = '0;
    for (int i = 0; i < TK; i++) r[62-i] = msg[i];
    r[11:0] = poly_mod(r);
    return r;
  endfunction

  function automatic logic [50:0] rand_msg();
    return 51'({$urandom(), $urandom()});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic [62:0] cw);
    for (int i = 0; i < TN; i++) tx_q.push_back(cw[62-i]);
    for (int i = 0; i < TK; i++) exp_bit_q.push_back(cw[62-i]);
    exp_syn_q.push_back(poly_mod(cw));
  endtask

  task automatic check_out();
    bit exp;
    if (exp_bit_q.size() == 0 || exp_syn_q.size() == 0) begin
      chk("unexpected_output", 32'(valid_out), 32'd0);
      return;
    end
    exp = exp_bit_q.pop_front();
    chk("data_out", 32'(data_out), 32'(exp));
    chk("last_out", 32'(last_out), 32'(out_pos == TK - 1));
    if (out_pos == 0 || out_pos == TK - 1) begin
      chk("syndrome_out", 32'(syndrome_out), 32'(exp_syn_q[0]));
      chk("err_out", 32'(err_out), 32'(exp_syn_q[0] != 12'h0));
    end
    if (out_pos == TK - 1) begin
      last_syn = syndrome_out;
      last_err = err_out;
      void'(exp_syn_q.pop_front());
      out_pos = 0;
    end else begin
      out_pos++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    ready_out = ($urandom_range(99) < ro_pct);
    valid_in  = (tx_q.size() > 0) && ($urandom_range(99) < vi_pct);
    data_in   = valid_in ? tx_q[0] : 1'($urandom_range(1));
    #1;
    s_vo = valid_out;
    if (tx_q.size() > 0 && !ready_in) ri_low_seen = 1'b1;
    if (valid_in && ready_in) begin
      void'(tx_q.pop_front());
      acc++;
    end
    if (valid_out && ready_out) check_out();
  endtask

  task automatic run_until_drained(input int bound);
    int n = 0;
    while ((tx_q.size() > 0 || exp_bit_q.size() > 0) && n < bound) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < bound), 32'd1);
  endtask

  task automatic run_until_acc(input int target, input int bound);
    int n = 0;
    while (acc < target && n < bound) begin
      step();
      n++;
    end
    chk("accept_timeout", 32'(n < bound), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    ready_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    exp_bit_q.delete();
    exp_syn_q.delete();
    out_pos = 0;
    acc = 0;
    #1;
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_last_out", 32'(last_out), 32'd0);
    chk("rst_err_out", 32'(err_out), 32'd0);
    chk("rst_syndrome", 32'(syndrome_out), 32'd0);
    chk("rst_blk_count", 32'(blk_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = 1'b0; ready_out = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // All-zero codeword; first message bit valid one cycle after the last input bit.
    vi_pct = 100; ro_pct = 100;
    push_block(63'h0);
    run_until_acc(TN, 200);
    step();
    chk("latency_valid_out", 32'(s_vo), 32'd1);
    run_until_drained(200);
    chk("zero_syndrome", 32'(last_syn), 32'h000);
    chk("zero_err", 32'(last_err), 32'd0);
    chk("zero_blk_count", 32'(blk_count), 32'd1);
    chk("zero_err_count", 32'(err_count), 32'd0);

    // Message bit 50 set with zero parity.
    push_block(63'h1000);
    run_until_drained(300);
    chk("msb50_syndrome", 32'(last_syn), 32'h539);
    chk("msb50_err", 32'(last_err), 32'd1);
    chk("msb50_err_count", 32'(err_count), 32'd1);
    chk("msb50_blk_count", 32'(blk_count), 32'd2);

    // First parity bit flipped.
    push_block(63'h800);
    run_until_drained(300);
    chk("par0_syndrome", 32'(last_syn), 32'h800);
    chk("par0_err", 32'(last_err), 32'd1);
    chk("par0_err_count", 32'(err_count), 32'd2);

    // 1000 valid random codewords back-to-back.
    do_reset();
    for (int b = 0; b < 1000; b++) push_block(encode(rand_msg()));
    ri_low_seen = 1'b0;
    run_until_drained(70000);
    chk("stream_ready_in_low", 32'(ri_low_seen), 32'd0);
    chk("stream_err_count", 32'(err_count), 32'd0);
    chk("stream_blk_count", 32'(blk_count), 32'd1000);

    // Backpressure: both banks fill, third codeword waits.
    do_reset();
    ro_pct = 0;
    for (int b = 0; b < 3; b++) push_block(encode(rand_msg()));
    run_until_acc(2 * TN, 400);
    repeat (10) step();
    chk("bp_accepted", 32'(acc), 32'(2 * TN));
    chk("bp_ready_in", 32'(ready_in), 32'd0);
    chk("bp_valid_out", 32'(s_vo), 32'd1);
    ro_pct = 100;
    run_until_drained(600);
    chk("bp_blk_count", 32'(blk_count), 32'd3);

    // Reset at in_cnt=30 of the second block while the first drains.
    do_reset();
    push_block(encode(rand_msg()));
    push_block(encode(rand_msg()));
    run_until_acc(TN + 30, 400);
    chk("mid_valid_before_rst", 32'(s_vo), 32'd1);
    do_reset();
    push_block(encode(rand_msg()));
    run_until_drained(300);
    chk("post_rst_syndrome", 32'(last_syn), 32'h000);
    chk("post_rst_blk_count", 32'(blk_count), 32'd1);

    // Random gaps, random backpressure, occasional single-bit errors.
    vi_pct = 70; ro_pct = 50;
    nerr = 0;
    for (int b = 0; b < 20; b++) begin
      logic [62:0] cw;
      cw = encode(rand_msg());
      if ($urandom_range(2) == 0) cw = cw ^ (63'h1 << $urandom_range(62));
      if (poly_mod(cw) != 12'h0) nerr++;
      push_block(cw);
    end
    run_until_drained(8000);
    chk("rand_err_count", 32'(err_count), 32'(nerr));
    chk("rand_blk_count", 32'(blk_count), 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
